audio_source_arbiter: RTL and testbench

Sequencer that shares the single codec DAC sample path between N_SRC sample sources (waveform generator, noise, tone presets). It sits between the sources and `audio_codec`, answering each codec `sample_req` with one sample from the selected source. It inserts a run of zero samples on every source change to avoid clicks. In round-robin mode it rotates through sources on a fixed slot length.

---
 rtl/audio_arb_pkg.sv | 17 +
 rtl/audio_source_arbiter_slot_timer.sv | 47 ++++
 rtl/audio_source_arbiter.sv | 139 +++++++++++++
 tb/tb_audio_source_arbiter.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/audio_arb_pkg.sv
// Shared types and helpers for the codec sample-path arbiter.
// State encoding matches the debug state port.
package audio_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_GAP  = 2'd1,
    ST_PLAY = 2'd2
  } arb_state_e;

  localparam int UND_W = 8;

  function automatic int sel_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/audio_source_arbiter_slot_timer.sv
// Round-robin slot counter and rotation target.
// rr_target follows the routed source while rotation is off.
module slot_timer
  import audio_arb_pkg::*;
#(
  parameter int  SLOT_LEN = 48000,
  parameter int  N_SRC    = 4,
  localparam int SELW     = sel_w(N_SRC)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            rr_mode,
  input  logic            adv,
  input  logic            clr,
  input  logic [SELW-1:0] active_src,
  input  logic [SELW-1:0] active_nxt,
  output logic [SELW-1:0] rr_target
);

  localparam int SW = $clog2(SLOT_LEN + 1);

  logic [SW-1:0]   slot_cnt;
  logic [SELW-1:0] nxt_src;
  logic            tc;

  assign tc = (slot_cnt == SW'(SLOT_LEN - 1));

  assign nxt_src = (active_src == SELW'(N_SRC - 1)) ?
                   '0 : active_src + SELW'(1);

  always_ff @(posedge clk) begin
    if (reset) begin
      slot_cnt  <= '0;
      rr_target <= '0;
    end else begin
      if (clr)
        slot_cnt <= '0;
      else if (adv)
        slot_cnt <= tc ? '0 : slot_cnt + SW'(1);
      if (!rr_mode)
        rr_target <= active_nxt;
      else if (adv && tc)
        rr_target <= nxt_src;
    end
  end

endmodule

// File: rtl/audio_source_arbiter.sv
// Shares the codec DAC sample path between N_SRC sources,
// inserting a run of zero samples on every source change.
module audio_source_arbiter
  import audio_arb_pkg::*;
#(
  parameter int  N_SRC    = 4,
  parameter int  W        = 16,
  parameter int  GAP_LEN  = 4,
  parameter int  SLOT_LEN = 48000,
  localparam int SELW     = sel_w(N_SRC)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic               rr_mode,
  input  logic [SELW-1:0]    sel,
  input  logic               sample_req,
  input  logic [N_SRC-1:0]   src_valid,
  input  logic [N_SRC*W-1:0] src_data,
  output logic [N_SRC-1:0]   src_ack,
  output logic [W-1:0]       audio_out,
  output logic [SELW-1:0]    active_src,
  output logic [UND_W-1:0]   underrun_cnt,
  output logic [1:0]         state
);

  localparam int GW = $clog2(GAP_LEN + 1);

  arb_state_e       st_q, st_d;
  logic [SELW-1:0]  target, act_d, rr_target;
  logic [GW-1:0]    gap_q, gap_d;
  logic [W-1:0]     aud_d;
  logic [N_SRC-1:0] ack_d;
  logic [UND_W-1:0] und_d;
  logic             start_gap, served, clr_slot;

  assign state = st_q;

  always_comb begin
    target = active_src;
    if (rr_mode)
      target = rr_target;
    else if (32'(sel) < N_SRC)
      target = sel;
  end

  always_ff @(posedge clk) begin
    if (reset) st_q <= ST_IDLE;
    else       st_q <= st_d;
  end

  always_comb begin
    st_d      = st_q;
    act_d     = active_src;
    gap_d     = gap_q;
    start_gap = 1'b0;
    served    = 1'b0;
    clr_slot  = 1'b0;
    if (!enable) begin
      st_d = ST_IDLE;
    end else if (sample_req) begin
      unique case (st_q)
        ST_IDLE: start_gap = 1'b1;
        ST_GAP: begin
          if (target != active_src) begin
            start_gap = 1'b1;
          end else begin
            gap_d = gap_q - GW'(1);
            if (gap_q == GW'(1)) begin
              st_d     = ST_PLAY;
              clr_slot = 1'b1;
            end
          end
        end
        ST_PLAY: begin
          if (target != active_src) start_gap = 1'b1;
          else                      served    = 1'b1;
        end
        default: st_d = ST_IDLE;
      endcase
    end
    // A one-sample gap is just the switching request itself
    if (start_gap) begin
      act_d    = target;
      gap_d    = GW'(GAP_LEN - 1);
      st_d     = (GAP_LEN == 1) ? ST_PLAY : ST_GAP;
      clr_slot = (GAP_LEN == 1);
    end
  end

  always_comb begin
    aud_d = audio_out;
    ack_d = '0;
    und_d = underrun_cnt;
    if (!enable) begin
      aud_d = '0;
    end else if (sample_req) begin
      if (!served) begin
        aud_d = '0;
      end else if (src_valid[active_src]) begin
        aud_d             = src_data[active_src*W +: W];
        ack_d[active_src] = 1'b1;
      end else if (underrun_cnt != '1) begin
        und_d = underrun_cnt + UND_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      active_src   <= '0;
      gap_q        <= '0;
      audio_out    <= '0;
      src_ack      <= '0;
      underrun_cnt <= '0;
    end else begin
      active_src   <= act_d;
      gap_q        <= gap_d;
      audio_out    <= aud_d;
      src_ack      <= ack_d;
      underrun_cnt <= und_d;
    end
  end

  slot_timer #(
    .SLOT_LEN (SLOT_LEN),
    .N_SRC    (N_SRC)
  ) u_slot (
    .clk        (clk),
    .reset      (reset),
    .rr_mode    (rr_mode),
    .adv        (served),
    .clr        (clr_slot),
    .active_src (active_src),
    .active_nxt (act_d),
    .rr_target  (rr_target)
  );

endmodule

// File: tb/tb_audio_source_arbiter.sv
// Scoreboard bench for audio_source_arbiter (GAP_LEN=4, SLOT_LEN=3).
// Expected responses are queued at issue and checked a cycle later.
module tb_audio_source_arbiter;

  logic        clk;
  logic        reset;
  logic        enable;
  logic        rr_mode;
  logic [1:0]  sel;
  logic        sample_req;
  logic [3:0]  src_valid;
  logic [63:0] src_data;
  logic [3:0]  src_ack;
  logic [15:0] audio_out;
  logic [1:0]  active_src;
  logic [7:0]  underrun_cnt;
  logic [1:0]  state;

  typedef struct {
    logic [15:0] a;
    logic [3:0]  k;
    logic [1:0]  s;
    logic [1:0]  act;
    logic [7:0]  u;
    string       nm;
  } exp_t;

  exp_t sbq[$];
  logic chk;
  logic pend;
  int   n_chk;
  int   n_pass;

  audio_source_arbiter #(
    .N_SRC    (4),
    .W        (16),
    .GAP_LEN  (4),
    .SLOT_LEN (3)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .rr_mode      (rr_mode),
    .sel          (sel),
    .sample_req   (sample_req),
    .src_valid    (src_valid),
    .src_data     (src_data),
    .src_ack      (src_ack),
    .audio_out    (audio_out),
    .active_src   (active_src),
    .underrun_cnt (underrun_cnt),
    .state        (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial pend = 1'b0;
  always @(posedge clk) pend <= chk;

  always @(negedge clk) begin
    if (pend) begin
      exp_t e;
      n_chk++;
      if (sbq.size() == 0) begin
        $display("FAIL sb_empty: output seen with no expectation");
      end else begin
        e = sbq.pop_front();
        if (audio_out !== e.a || src_ack !== e.k || state !== e.s ||
            active_src !== e.act || underrun_cnt !== e.u)
          $display("FAIL %s got a=%h k=%b s=%0d act=%0d u=%0d want a=%h k=%b s=%0d act=%0d u=%0d",
                   e.nm, audio_out, src_ack, state, active_src, underrun_cnt,
                   e.a, e.k, e.s, e.act, e.u);
        else
          n_pass++;
      end
    end
  end

  task automatic go(input logic rq, input logic [15:0] a,
                    input logic [3:0] k, input logic [1:0] s,
                    input logic [1:0] act, input logic [7:0] u,
                    input string nm);
    exp_t e;
    e.a = a; e.k = k; e.s = s; e.act = act; e.u = u; e.nm = nm;
    sample_req = rq;
    chk = 1'b1;
    sbq.push_back(e);
    @(negedge clk); #1;
  endtask

  task automatic idle(input logic rq);
    sample_req = rq;
    chk = 1'b0;
    @(negedge clk); #1;
  endtask

  initial begin
    n_chk = 0;
    n_pass = 0;
    reset = 1'b1;
    enable = 1'b0;
    rr_mode = 1'b0;
    sel = 2'd0;
    sample_req = 1'b0;
    chk = 1'b0;
    src_valid = 4'hF;
    src_data = {16'h4003, 16'h1234, 16'h2001, 16'h1000};
    @(negedge clk); #1;

    go(0, 16'h0, 4'b0000, 0, 0, 0, "reset");
    reset = 1'b0; enable = 1'b1; sel = 2'd2;
    go(1, 16'h0, 4'b0000, 1, 2, 0, "gap1");
    idle(0);
    go(1, 16'h0, 4'b0000, 1, 2, 0, "gap2");
    go(1, 16'h0, 4'b0000, 1, 2, 0, "gap3");
    go(1, 16'h0, 4'b0000, 2, 2, 0, "gap4");
    go(1, 16'h1234, 4'b0100, 2, 2, 0, "play2");
    go(0, 16'h1234, 4'b0000, 2, 2, 0, "hold2");

    sel = 2'd1;
    go(1, 16'h0, 4'b0000, 1, 1, 0, "sw1_z1");
    go(1, 16'h0, 4'b0000, 1, 1, 0, "sw1_z2");
    go(1, 16'h0, 4'b0000, 1, 1, 0, "sw1_z3");
    go(1, 16'h0, 4'b0000, 2, 1, 0, "sw1_z4");
    go(1, 16'h2001, 4'b0010, 2, 1, 0, "play1");

    sel = 2'd2;
    go(1, 16'h0, 4'b0000, 1, 2, 0, "back_z1");
    go(1, 16'h0, 4'b0000, 1, 2, 0, "back_z2");
    go(1, 16'h0, 4'b0000, 1, 2, 0, "back_z3");
    go(1, 16'h0, 4'b0000, 2, 2, 0, "back_z4");
    go(1, 16'h1234, 4'b0100, 2, 2, 0, "back_play");
    src_valid = 4'b1011;
    go(1, 16'h1234, 4'b0000, 2, 2, 1, "under1");
    go(1, 16'h1234, 4'b0000, 2, 2, 2, "under2");
    go(1, 16'h1234, 4'b0000, 2, 2, 3, "under3");
    for (int i = 0; i < 296; i++) idle(1);
    go(1, 16'h1234, 4'b0000, 2, 2, 255, "under_sat");
    src_valid = 4'hF;
    go(1, 16'h1234, 4'b0100, 2, 2, 255, "under_recover");

    sel = 2'd0;
    go(1, 16'h0, 4'b0000, 1, 0, 255, "rg_z1");
    go(1, 16'h0, 4'b0000, 1, 0, 255, "rg_z2");
    sel = 2'd3;
    go(1, 16'h0, 4'b0000, 1, 3, 255, "rg_re3");
    sel = 2'd1;
    go(1, 16'h0, 4'b0000, 1, 1, 255, "rg_re1");
    go(1, 16'h0, 4'b0000, 1, 1, 255, "rg_z5");
    go(1, 16'h0, 4'b0000, 1, 1, 255, "rg_z6");
    go(1, 16'h0, 4'b0000, 2, 1, 255, "rg_z7");
    go(1, 16'h2001, 4'b0010, 2, 1, 255, "rg_play1");

    sel = 2'd3;
    go(1, 16'h0, 4'b0000, 1, 3, 255, "en_gap");
    enable = 1'b0;
    go(0, 16'h0, 4'b0000, 0, 3, 255, "en_off");
    go(1, 16'h0, 4'b0000, 0, 3, 255, "en_off_req");

    rr_mode = 1'b1; enable = 1'b1;
    go(1, 16'h0, 4'b0000, 1, 3, 255, "rr3_z1");
    go(1, 16'h0, 4'b0000, 1, 3, 255, "rr3_z2");
    go(1, 16'h0, 4'b0000, 1, 3, 255, "rr3_z3");
    go(1, 16'h0, 4'b0000, 2, 3, 255, "rr3_z4");
    go(1, 16'h4003, 4'b1000, 2, 3, 255, "rr3_a");
    go(1, 16'h4003, 4'b1000, 2, 3, 255, "rr3_b");
    go(1, 16'h4003, 4'b1000, 2, 3, 255, "rr3_c");
    go(1, 16'h0, 4'b0000, 1, 0, 255, "rr0_z1");
    go(1, 16'h0, 4'b0000, 1, 0, 255, "rr0_z2");
    go(1, 16'h0, 4'b0000, 1, 0, 255, "rr0_z3");
    go(1, 16'h0, 4'b0000, 2, 0, 255, "rr0_z4");
    go(1, 16'h1000, 4'b0001, 2, 0, 255, "rr0_a");
    go(1, 16'h1000, 4'b0001, 2, 0, 255, "rr0_b");
    go(1, 16'h1000, 4'b0001, 2, 0, 255, "rr0_c");
    go(1, 16'h0, 4'b0000, 1, 1, 255, "rr1_z1");
    go(1, 16'h0, 4'b0000, 1, 1, 255, "rr1_z2");
    go(1, 16'h0, 4'b0000, 1, 1, 255, "rr1_z3");
    go(1, 16'h0, 4'b0000, 2, 1, 255, "rr1_z4");
    go(1, 16'h2001, 4'b0010, 2, 1, 255, "rr1_a");

    reset = 1'b1;
    go(1, 16'h0, 4'b0000, 0, 0, 0, "rst_play");
    reset = 1'b0;
    idle(0);
    idle(0);

    n_chk++;
    if (sbq.size() != 0)
      $display("FAIL sb_drain: %0d left, want 0", sbq.size());
    else
      n_pass++;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
